// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Each digit slot is a blanking interval followed by an on interval. The segment pattern is captured once per slot.
module seg7_scan_ctrl #(
  parameter int unsigned DIGIT_TICKS = 50000,
  parameter int unsigned BLANK_TICKS = 500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_digit_en,
  input  logic [7:0] i_mux_data,
  output logic [1:0] o_ctrl,
  output logic [7:0] o_seg,
  output logic [3:0] o_an,
  output logic       o_frame
);

  localparam int unsigned CW       = $clog2(DIGIT_TICKS);
  localparam int unsigned ON_TICKS = DIGIT_TICKS - BLANK_TICKS;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    digit;
  logic [CW-1:0] cnt;
  logic [3:0]    an_on_c;

  // Anode pattern for the current digit while lit; a disabled digit stays dark.
  always_comb begin
    an_on_c = 4'b1111;
    if (i_digit_en[digit]) begin
      an_on_c = ~(4'b0001 << digit);
    end
  end

  assign o_ctrl = digit;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      digit   <= 2'd0;
      cnt     <= '0;
      o_seg   <= 8'h00;
      o_an    <= 4'b1111;
      o_frame <= 1'b0;
    end else begin
      o_frame <= 1'b0;
      case (state)
        IDLE: begin
          digit <= 2'd0;
          cnt   <= '0;
          o_an  <= 4'b1111;
          if (i_en) begin
            state <= BLANK;
          end
        end
        BLANK: begin
          if (!i_en) begin
            state <= IDLE;
            digit <= 2'd0;
            cnt   <= '0;
            o_an  <= 4'b1111;
          end else if (cnt == BLANK_LAST) begin
            // The mux has had the whole blank interval to settle on this digit.
            state <= ON;
            cnt   <= '0;
            o_seg <= i_mux_data;
            o_an  <= an_on_c;
          end else begin
            cnt  <= cnt + CW'(1);
            o_an <= 4'b1111;
          end
        end
        ON: begin
          if (!i_en) begin
            state <= IDLE;
            digit <= 2'd0;
            cnt   <= '0;
            o_an  <= 4'b1111;
          end else if (cnt == ON_LAST) begin
            state   <= BLANK;
            cnt     <= '0;
            digit   <= digit + 2'd1;
            o_an    <= 4'b1111;
            o_frame <= (digit == 2'd3);
          end else begin
            cnt  <= cnt + CW'(1);
            o_an <= an_on_c;
          end
        end
        default: begin
          state <= IDLE;
          digit <= 2'd0;
          cnt   <= '0;
          o_an  <= 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl against a slot-position reference model.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

  localparam int DT = 10;
  localparam int BT = 2;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_en = 1'b0;
  logic [3:0] i_digit_en = 4'hF;
  logic [7:0] i_mux_data;
  logic [1:0] o_ctrl;
  logic [7:0] o_seg;
  logic [3:0] o_an;
  logic       o_frame;

  logic [7:0] mux_table [4];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  seg7_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_digit_en(i_digit_en),
    .i_mux_data(i_mux_data), .o_ctrl(o_ctrl), .o_seg(o_seg), .o_an(o_an), .o_frame(o_frame)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  assign i_mux_data = mux_table[o_ctrl];

  // Reference: m_p counts cycles since the scan started; slot = p/DT, phase = p%DT.
  logic       m_run = 1'b0;
  int         m_p = 0;
  logic [7:0] m_seg = 8'h00;
  logic [3:0] m_an = 4'hF;
  logic       m_frame = 1'b0;
  logic [1:0] m_ctrl;
  assign m_ctrl = m_run ? 2'((m_p / DT) % 4) : 2'd0;

  always @(posedge i_clk or negedge i_rst) begin : model
    int np;
    int d;
    if (!i_rst) begin
      m_run <= 1'b0; m_p <= 0; m_seg <= 8'h00; m_an <= 4'hF; m_frame <= 1'b0;
    end else if (!i_en) begin
      m_run <= 1'b0; m_p <= 0; m_an <= 4'hF; m_frame <= 1'b0;
    end else begin
      np = m_run ? m_p + 1 : 0;
      d  = (np / DT) % 4;
      m_run <= 1'b1;
      m_p   <= np;
      if (np % DT == BT) m_seg <= mux_table[d];
      m_frame <= (np > 0) && (np % (4 * DT) == 0);
      m_an <= ((np % DT) < BT || !i_digit_en[d]) ? 4'hF : ~(4'b0001 << d);
    end
  end

  task automatic set_table(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    mux_table[0] = a; mux_table[1] = b; mux_table[2] = c; mux_table[3] = d;
  endtask

  task automatic test_reset();
    set_table(8'h3F, 8'h06, 8'h5B, 8'h4F);
    repeat (3) @(negedge i_clk);
    tests++;
    if ({o_ctrl, o_seg, o_an, o_frame} !== {2'd0, 8'h00, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL reset_hold got ctrl=%0d seg=%h an=%b fr=%b want 0/00/1111/0", o_ctrl, o_seg, o_an, o_frame);
    end
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    tests++;
    if ({o_ctrl, o_seg, o_an, o_frame} !== {2'd0, 8'h00, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL reset_idle got ctrl=%0d seg=%h an=%b fr=%b want 0/00/1111/0", o_ctrl, o_seg, o_an, o_frame);
    end
  endtask

  task automatic test_scan(input logic [3:0] den, input string name);
    int last_fr = -1;
    int nfr = 0;
    i_digit_en = den;
    i_en = 1'b1;
    for (int n = 0; n < 12 * DT + 3; n++) begin
      @(negedge i_clk);
      tests++;
      if ({o_ctrl, o_seg, o_an, o_frame} !== {m_ctrl, m_seg, m_an, m_frame}) begin
        fails++;
        $display("FAIL %s cyc=%0d got ctrl=%0d seg=%h an=%b fr=%b want %0d/%h/%b/%b",
                 name, cyc, o_ctrl, o_seg, o_an, o_frame, m_ctrl, m_seg, m_an, m_frame);
      end
      if (o_frame) begin
        if (last_fr >= 0) begin
          tests++;
          if (cyc - last_fr != 4 * DT) begin
            fails++;
            $display("FAIL %s_frame_period got %0d want %0d", name, cyc - last_fr, 4 * DT);
          end
        end
        last_fr = cyc;
        nfr++;
      end
    end
    tests++;
    if (nfr != 3) begin
      fails++;
      $display("FAIL %s_frame_count got %0d want 3", name, nfr);
    end
    i_en = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_seg_hold();
    int guard = 0;
    set_table(8'h3F, 8'h06, 8'h5B, 8'h4F);
    i_digit_en = 4'hF;
    i_en = 1'b1;
    while (!(m_ctrl == 2'd1 && m_an == 4'b1101 && (m_p % DT) == BT + 2) && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    tests++;
    if (guard >= 200) begin fails++; $display("FAIL seg_hold_timeout got %0d want <200", guard); end
    mux_table[1] = 8'h7F;
    for (int n = 0; n < 4 * DT + 2; n++) begin
      @(negedge i_clk);
      tests++;
      if ({o_ctrl, o_seg, o_an, o_frame} !== {m_ctrl, m_seg, m_an, m_frame}) begin
        fails++;
        $display("FAIL seg_hold cyc=%0d got ctrl=%0d seg=%h an=%b fr=%b want %0d/%h/%b/%b",
                 cyc, o_ctrl, o_seg, o_an, o_frame, m_ctrl, m_seg, m_an, m_frame);
      end
      if (o_ctrl == 2'd1 && o_an == 4'b1101) begin
        tests++;
        if (o_seg !== ((n < DT) ? 8'h06 : 8'h7F)) begin
          fails++;
          $display("FAIL seg_hold_value n=%0d got %h want %h", n, o_seg, (n < DT) ? 8'h06 : 8'h7F);
        end
      end
    end
    i_en = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_disable();
    int guard = 0;
    set_table(8'(($urandom)), 8'(($urandom)), 8'(($urandom)), 8'(($urandom)));
    i_digit_en = 4'hF;
    i_en = 1'b1;
    while (!(m_p == 2 * DT + BT + 3) && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    tests++;
    if (guard >= 200 || o_an !== 4'b1011) begin
      fails++; $display("FAIL disable_setup got an=%b want 1011", o_an);
    end
    i_en = 1'b0;
    @(negedge i_clk);
    tests++;
    if ({o_ctrl, o_an, o_frame} !== {2'd0, 4'hF, 1'b0}) begin
      fails++; $display("FAIL disable_idle got ctrl=%0d an=%b fr=%b want 0/1111/0", o_ctrl, o_an, o_frame);
    end
    repeat (3) @(negedge i_clk);
    i_en = 1'b1;
    for (int n = 1; n <= 2 * DT; n++) begin
      @(negedge i_clk);
      tests++;
      if ({o_ctrl, o_seg, o_an, o_frame} !== {m_ctrl, m_seg, m_an, m_frame}) begin
        fails++;
        $display("FAIL reenable cyc=%0d got ctrl=%0d seg=%h an=%b fr=%b want %0d/%h/%b/%b",
                 cyc, o_ctrl, o_seg, o_an, o_frame, m_ctrl, m_seg, m_an, m_frame);
      end
      tests++;
      if (o_an !== ((n <= BT || n > DT) ? 4'hF : 4'b1110) && n <= DT + BT) begin
        fails++; $display("FAIL reenable_an n=%0d got %b", n, o_an);
      end
    end
    i_en = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_async_reset();
    int guard = 0;
    i_digit_en = 4'hF;
    i_en = 1'b1;
    while (!(m_ctrl == 2'd3 && m_an == 4'b0111) && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    #1;
    tests++;
    if ({o_ctrl, o_seg, o_an, o_frame} !== {2'd0, 8'h00, 4'hF, 1'b0} || guard >= 200) begin
      fails++;
      $display("FAIL async_reset got ctrl=%0d seg=%h an=%b fr=%b want 0/00/1111/0", o_ctrl, o_seg, o_an, o_frame);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int n = 1; n <= DT + 2; n++) begin
      @(negedge i_clk);
      tests++;
      if ({o_ctrl, o_seg, o_an, o_frame} !== {m_ctrl, m_seg, m_an, m_frame}) begin
        fails++;
        $display("FAIL after_reset cyc=%0d got ctrl=%0d seg=%h an=%b fr=%b want %0d/%h/%b/%b",
                 cyc, o_ctrl, o_seg, o_an, o_frame, m_ctrl, m_seg, m_an, m_frame);
      end
    end
    tests++;
    if (o_ctrl !== 2'd1) begin fails++; $display("FAIL after_reset_digit got %0d want 1", o_ctrl); end
    i_en = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_random();
    set_table(8'(($urandom)), 8'(($urandom)), 8'(($urandom)), 8'(($urandom)));
    i_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge i_clk);
      tests++;
      if ({o_ctrl, o_seg, o_an, o_frame} !== {m_ctrl, m_seg, m_an, m_frame}) begin
        fails++;
        $display("FAIL random cyc=%0d got ctrl=%0d seg=%h an=%b fr=%b want %0d/%h/%b/%b",
                 cyc, o_ctrl, o_seg, o_an, o_frame, m_ctrl, m_seg, m_an, m_frame);
      end
      tests++;
      if ($countones(~o_an) > 1) begin fails++; $display("FAIL random_onehot got an=%b want <=1 low", o_an); end
      if ($urandom_range(0, 59) == 0) i_en = ~i_en;
      if ($urandom_range(0, 6) == 0) i_digit_en = 4'($urandom);
      if ($urandom_range(0, 99) == 0) mux_table[$urandom_range(0, 3)] = 8'($urandom);
    end
    i_en = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    set_table(8'h3F, 8'h06, 8'h5B, 8'h4F);
    test_scan(4'hF, "scan_all");
    test_scan(4'b1010, "scan_1010");
    set_table(8'(($urandom)), 8'(($urandom)), 8'(($urandom)), 8'(($urandom)));
    test_scan(4'($urandom), "scan_rand");
    test_seg_hold();
    test_disable();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit 7-segment display.
- Drives the 2-bit select of the 4:1 8-bit segment multiplexer and takes the mux output back.
- Registers the selected segment pattern and drives one common-anode digit at a time.
- Inserts a dead-time (blanking) interval at every digit change to suppress ghosting.
- Sits between the display-data registers/mux and the board segment/anode pins.

Parameters:
DIGIT_TICKS, 50000, clock cycles per digit slot, blank plus on time (1 kHz digit rate at 50 MHz); must satisfy DIGIT_TICKS > BLANK_TICKS.
BLANK_TICKS, 500, clock cycles at the start of each slot with all anodes off; must be >= 1.
CW, $clog2(DIGIT_TICKS), slot counter width; derived, not overridden.

Ports:
i_clk  input  1  system clock; all state on rising edge.
i_rst  input  1  asynchronous, active-low reset (asserted = 0).
i_en  input  1  scan enable; 0 = display dark, scan parked.
i_digit_en  input  4  per-digit enable; bit k = 0 keeps anode k off during its slot, but the slot time is still consumed.
i_mux_data  input  8  segment pattern returned from the mux for the current o_ctrl.
o_ctrl  output  2  mux select, equal to the current digit index 0..3.
o_seg  output  8  registered segment pattern, active-high, bit order as i_mux_data.
o_an  output  4  digit anodes, active-low, one-hot-low or all ones.
o_frame  output  1  one-cycle pulse when digit 3's slot completes.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE, digit=0, cnt=0, o_ctrl=2'b00, o_seg=8'h00, o_an=4'b1111, o_frame=0.
- States:
  - IDLE: o_an=4'b1111, o_ctrl=0, cnt=0, digit=0. When i_en=1 at a clock edge, go to BLANK (digit 0, cnt=0).
  - BLANK: o_an=4'b1111, o_ctrl=digit, cnt increments each cycle. On the edge where cnt==BLANK_TICKS-1: go to ON, cnt<=0, o_seg<=i_mux_data.
  - ON: o_an[k]=0 only for k==digit and only if i_digit_en[digit]=1, else 4'b1111. Lasts ON_TICKS=DIGIT_TICKS-BLANK_TICKS cycles. On the edge where cnt==ON_TICKS-1: digit<=digit+1 (3 wraps to 0), cnt<=0, go to BLANK.
- o_ctrl changes only on the ON->BLANK edge. Mux output therefore has the full blank interval to settle before capture.
- o_seg:
  - Captured once per slot, on the BLANK->ON edge.
  - Changes to i_mux_data during ON are ignored until the next slot.
  - Holds its last value in IDLE.
- o_an is registered; it is never low for two digits and never low during BLANK or IDLE.
- o_frame=1 for exactly the cycle after the ON->BLANK edge where digit wraps 3->0; otherwise 0.
- i_en deassert in BLANK or ON: on the next edge go to IDLE, o_an<=4'b1111, digit<=0, cnt<=0, no o_frame. Re-enable restarts at digit 0 with a full BLANK.
- i_digit_en is sampled every cycle during ON; a mid-slot change takes effect on the next cycle.
- Slot period is exactly DIGIT_TICKS cycles; frame period is exactly 4*DIGIT_TICKS cycles, independent of i_digit_en.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.

Test Plan:
1. DIGIT_TICKS=10, BLANK_TICKS=2; reset, then i_en=1, i_digit_en=4'hF, mux model returning 8'h3F,06,5B,4F for ctrl 0..3 -> o_an sequence: 1111 for 2 cycles, 1110 for 8, 1111 for 2, 1101 for 8, then 1011 and 0111 phases; o_seg=3F,06,5B,4F in each ON phase; o_frame one pulse every 40 cycles.
2. i_digit_en=4'b1010 -> o_an stays 1111 during digit 0 and 2 slots; digit 1 and 3 timing unchanged; frame period still 40 cycles.
3. Change the mux data for the current digit from 8'h06 to 8'h7F mid-ON -> o_seg stays 8'h06 until that digit's next slot; never shows a partial update.
4. Drop i_en in the 4th cycle of digit 2's ON phase -> next edge o_an=1111, o_ctrl=0, no o_frame; re-enable gives 2 blank cycles, then digit 0.
5. Pull i_rst low between clock edges during digit 3 ON -> outputs reach reset values before the next edge; after release with i_en=1, scan restarts at digit 0.
6. Assertion run over 1000 cycles with random i_en/i_digit_en -> o_an never has more than one zero; o_an==1111 whenever state is BLANK; o_ctrl stable throughout each BLANK+ON slot.
